// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side adapter that drains a FIFO with a one-cycle
// registered read latency and presents its words as a valid/ready stream at
// full throughput, framed into BURST_LEN-word bursts, with a running word count.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous active-high reset
//   en           in   fetch enable; buffered words still drain while low
//   fifo_empty   in   FIFO empty flag
//   fifo_rd_data in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   out  FIFO read strobe (combinational)
//   m_valid      out  output word valid
//   m_data       out  output word (buffer head)
//   m_last       out  last word of a burst
//   m_ready      in   downstream accept
//   word_count   out  words accepted downstream since reset (wrapping)
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int unsigned BIDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, tail_q;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  pop;
  logic [2:0]            committed;

  // Output view of the 2-entry buffer.
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = mem_q[head_q];
  assign m_last     = m_valid & (bidx_q == BIDX_LAST);
  assign word_count = count_q;

  // Read issue and next-state: committed counts buffered plus in-flight words
  // after this cycle's pop, so a read is only issued when a slot is guaranteed.
  always_comb begin
    pop        = m_valid & m_ready;
    committed  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    fifo_rd_en = ~rst & en & ~fifo_empty & (committed < 3'd2);
    inflight_d = fifo_rd_en;
    occ_d      = committed[1:0];
    bidx_d     = bidx_q;
    count_d    = count_q;
    if (pop) begin
      bidx_d  = (bidx_q == BIDX_LAST) ? '0 : bidx_q + BIDX_W'(1);
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // State registers; capture and pop may happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      bidx_q     <= '0;
      count_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      bidx_q     <= bidx_d;
      count_q    <= count_d;
      if (inflight_q) begin
        mem_q[tail_q] <= fifo_rd_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a FIFO model with one-cycle read
// latency feeds the DUT; a per-cycle scoreboard checks order, m_last framing,
// hold stability and word_count; table vectors plus directed corner sequences.
module tb_fifo_stream_reader;

  localparam int BL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [31:0] word_count;

  fifo_stream_reader #(.DATA_WIDTH(16), .BURST_LEN(BL), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, discarded on reset.
  logic [15:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int underflow = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= wr_ptr;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      else begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  int errs = 0;
  int checks = 0;

  // Scoreboard state
  int          exp_ptr = 0;
  int          cnt_m = 0;
  int          bidx_m = 0;
  bit          hold_q = 1'b0;
  logic [15:0] hold_d;
  logic        hold_l;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // One clock cycle: observe at negedge, commit model at posedge, resume at +1.
  task automatic step();
    bit pend;
    logic [15:0] exp_w;
    pend = 1'b0;
    @(negedge clk);
    if (!rst) begin
      chk(word_count == 32'(cnt_m), "word_count", longint'(word_count), longint'(cnt_m));
      if (hold_q)
        chk(m_valid && m_data == hold_d && m_last == hold_l, "hold_stable",
            longint'({m_valid, m_last, m_data}), longint'({1'b1, hold_l, hold_d}));
      if (!m_valid) chk(m_last == 1'b0, "last_idle", longint'(m_last), 0);
      if (m_valid && m_ready) begin
        chk(exp_ptr < wr_ptr, "extra_word", longint'(exp_ptr), longint'(wr_ptr));
        exp_w = mem[exp_ptr];
        chk(m_data == exp_w, "data_order", longint'(m_data), longint'(exp_w));
        chk(m_last == (bidx_m == BL - 1), "m_last", longint'(m_last), longint'(bidx_m == BL - 1));
        pend = 1'b1;
      end
      hold_q = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
    @(posedge clk);
    if (rst) begin
      exp_ptr = wr_ptr;
      cnt_m   = 0;
      bidx_m  = 0;
      hold_q  = 1'b0;
    end else if (pend) begin
      exp_ptr++;
      cnt_m++;
      bidx_m = (bidx_m == BL - 1) ? 0 : bidx_m + 1;
    end
    #1;
  endtask

  task automatic wait_cnt(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (cnt_m != target && i < budget) begin
      step();
      i++;
    end
    chk(word_count == 32'(target), name, longint'(word_count), longint'(target));
  endtask

  typedef struct {
    int nload;
    bit en;
    bit rdy;
    int cycles;
    int d_cnt;
    int d_rd;
    bit valid;
    int level;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt0, rd0, lvl0, k, base;

    vecs[0] = '{0, 1'b1, 1'b1, 20, 0, 0, 1'b0, 0};  // empty FIFO: no reads
    vecs[1] = '{3, 1'b0, 1'b1, 10, 0, 0, 1'b0, 3};  // en low: nothing fetched
    vecs[2] = '{0, 1'b1, 1'b1, 10, 3, 3, 1'b0, 0};  // en back: all delivered
    vecs[3] = '{2, 1'b1, 1'b0, 10, 0, 2, 1'b1, 0};  // stalled: buffer fills
    vecs[4] = '{3, 1'b1, 1'b0, 10, 0, 0, 1'b1, 3};  // full buffer: no reads
    vecs[5] = '{0, 1'b1, 1'b1, 12, 5, 3, 1'b0, 0};  // release: drain 5
    vecs[6] = '{5, 1'b0, 1'b0,  5, 0, 0, 1'b0, 5};  // idle
    vecs[7] = '{0, 1'b1, 1'b1, 10, 5, 5, 1'b0, 0};  // stream 5

    rst = 1'b1; en = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk(fifo_rd_en == 1'b0, "rst_rd_en", longint'(fifo_rd_en), 0);
    chk(m_valid == 1'b0, "rst_valid", longint'(m_valid), 0);
    chk(m_last == 1'b0, "rst_last", longint'(m_last), 0);
    chk(m_data == 16'h0, "rst_data", longint'(m_data), 0);
    chk(word_count == 32'h0, "rst_count", longint'(word_count), 0);

    // First word latency
    en = 1'b1; m_ready = 1'b1;
    push(16'hBEEF);
    #1;
    chk(fifo_rd_en == 1'b1, "first_rd_en", longint'(fifo_rd_en), 1);
    step();
    chk(fifo_rd_en == 1'b0, "rd_en_once", longint'(fifo_rd_en), 0);
    chk(m_valid == 1'b0, "lat_valid_n1", longint'(m_valid), 0);
    step();
    chk(m_valid == 1'b1, "lat_valid_n2", longint'(m_valid), 1);
    chk(m_data == 16'hBEEF, "first_data", longint'(m_data), 16'hBEEF);
    step();
    chk(word_count == 32'd1, "first_count", longint'(word_count), 1);

    // Table-driven vectors
    for (int t = 0; t < 8; t++) begin
      en = vecs[t].en;
      m_ready = vecs[t].rdy;
      for (int i = 0; i < vecs[t].nload; i++) push(16'($urandom));
      cnt0 = cnt_m;
      rd0 = rd_cnt;
      repeat (vecs[t].cycles) step();
      chk(word_count == 32'(cnt0 + vecs[t].d_cnt), $sformatf("v%0d_count", t),
          longint'(word_count), longint'(cnt0 + vecs[t].d_cnt));
      chk(rd_cnt - rd0 == vecs[t].d_rd, $sformatf("v%0d_reads", t),
          longint'(rd_cnt - rd0), longint'(vecs[t].d_rd));
      chk(m_valid == vecs[t].valid, $sformatf("v%0d_valid", t),
          longint'(m_valid), longint'(vecs[t].valid));
      chk(wr_ptr - rd_ptr == vecs[t].level, $sformatf("v%0d_level", t),
          longint'(wr_ptr - rd_ptr), longint'(vecs[t].level));
    end

    // Streaming 64 words at full rate
    en = 1'b1; m_ready = 1'b1;
    base = cnt_m;
    for (int i = 0; i < 64; i++) push(16'($urandom));
    k = 0;
    while (cnt_m != base + 64 && k < 200) begin
      step();
      k++;
    end
    chk(k == 66, "stream_cycles", longint'(k), 66);
    chk(word_count == 32'(base + 64), "stream_count", longint'(word_count), longint'(base + 64));

    // Backpressure mid-stream
    base = cnt_m;
    for (int i = 0; i < 40; i++) push(16'($urandom));
    repeat (6) step();
    m_ready = 1'b0;
    rd0 = rd_cnt;
    repeat (10) step();
    chk(rd_cnt - rd0 <= 2, "stall_reads", longint'(rd_cnt - rd0), 2);
    chk(m_valid == 1'b1, "stall_valid", longint'(m_valid), 1);
    m_ready = 1'b1;
    #1;
    chk(fifo_rd_en == 1'b1, "resume_rd_en", longint'(fifo_rd_en), 1);
    wait_cnt(base + 40, 100, "bp_count");

    // Enable gating
    base = cnt_m;
    for (int i = 0; i < 40; i++) push(16'($urandom));
    k = 0;
    while (wr_ptr - rd_ptr > 30 && k < 50) begin
      step();
      k++;
    end
    en = 1'b0;
    #1;
    lvl0 = wr_ptr - rd_ptr;
    rd0 = rd_cnt;
    repeat (10) step();
    chk(rd_cnt == rd0, "en_low_reads", longint'(rd_cnt - rd0), 0);
    chk(wr_ptr - rd_ptr == lvl0, "en_low_level", longint'(wr_ptr - rd_ptr), longint'(lvl0));
    chk(m_valid == 1'b0, "en_low_drained", longint'(m_valid), 0);
    en = 1'b1;
    wait_cnt(base + 40, 100, "en_count");

    // Reset mid-burst
    base = cnt_m;
    for (int i = 0; i < 20; i++) push(16'($urandom));
    k = 0;
    while (!(bidx_m == 5 && cnt_m > base) && k < 40) begin
      step();
      k++;
    end
    chk(bidx_m == 5, "pre_rst_bidx", longint'(bidx_m), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk(m_valid == 1'b0, "arst_valid", longint'(m_valid), 0);
    chk(m_last == 1'b0, "arst_last", longint'(m_last), 0);
    chk(m_data == 16'h0, "arst_data", longint'(m_data), 0);
    chk(fifo_rd_en == 1'b0, "arst_rd_en", longint'(fifo_rd_en), 0);
    chk(word_count == 32'h0, "arst_count", longint'(word_count), 0);
    step();
    rst = 1'b0;
    #1;
    chk(word_count == 32'h0, "post_rst_count", longint'(word_count), 0);
    for (int i = 0; i < 10; i++) push(16'($urandom));
    wait_cnt(10, 60, "post_rst_words");

    repeat (3) step();
    chk(underflow == 0, "underflow", longint'(underflow), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
